// File: rtl/ff_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the SR-based flip-flop cells.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ff_pkg;

   // SR action encoding, {s, r}
   localparam logic [1:0] SR_HOLD    = 2'b00;
   localparam logic [1:0] SR_RESET   = 2'b01;
   localparam logic [1:0] SR_SET     = 2'b10;
   localparam logic [1:0] SR_INVALID = 2'b11;

   // Per-bit value loaded by reset (and by the s=r=1 case, which is reset-dominant)
   localparam logic Q_RST = 1'b0;

endpackage : ff_pkg

// File: rtl/sr_ff.sv
`timescale 1ns/1ps
// Vector of clocked SR flip-flops with synchronous active-high reset and qn = ~q.
// Latency: one clk edge from s/r to q.
// Backpressure: none; every edge is acted on.
module sr_ff
   import ff_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic bit_d;
      logic bit_q;

      // SR action table; s=r=1 clears, so the cell never holds an ambiguous state
      always_comb begin
         bit_d = bit_q;
         case ({s[i], r[i]})
            SR_HOLD:    bit_d = bit_q;
            SR_SET:     bit_d = 1'b1;
            SR_RESET:   bit_d = 1'b0;
            SR_INVALID: bit_d = Q_RST;
            default:    bit_d = bit_q;
         endcase
      end

      // State register; reset outranks any s/r action
      always_ff @(posedge clk) begin
         if (reset) begin
            bit_q <= Q_RST;
         end else begin
            bit_q <= bit_d;
         end
      end

      assign q[i]  = bit_q;
      assign qn[i] = ~bit_q;
   end

endmodule : sr_ff

// File: rtl/dff_using_srff.sv
`timescale 1ns/1ps
// D flip-flop vector built by driving an SR core with s = d, r = ~d.
// Latency: one clk from d to q; synchronous reset clears q.
// Backpressure: none; d is captured on every rising edge.
module dff_using_srff
   import ff_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] qn_unused;

   // D-to-SR conversion: s and r are always complementary, so s=r=1 cannot occur
   always_comb begin
      s = d;
      r = ~d;
   end

   sr_ff #(
      .WIDTH (WIDTH)
   ) u_sr_ff (
      .clk   (clk),
      .reset (reset),
      .s     (s),
      .r     (r),
      .q     (q),
      .qn    (qn_unused)
   );

endmodule : dff_using_srff

// File: tb/tb_dff_using_srff.sv
`timescale 1ns/1ps
// Directed bench for dff_using_srff at WIDTH=1 and WIDTH=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_dff_using_srff;

   logic       clk;
   logic       reset;
   logic       d1;
   logic       q1;
   logic [3:0] d4;
   logic [3:0] q4;

   int vectors;
   int miscompares;

   dff_using_srff #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .d     (d1),
      .reset (reset),
      .q     (q1)
   );

   dff_using_srff #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .d     (d4),
      .reset (reset),
      .q     (q4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      d1    = 1'b1;
      d4    = 4'b1111;
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_clear_q1: got %b want 0", q1);
      end
      vectors++;
      if (q4 !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_clear_q4: got %b want 0000", q4);
      end
      @(negedge clk);
      reset = 1'b0;
      d1    = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release: got %b want 1", q1);
      end
   endtask

   task automatic test_data_follow();
      logic       pat  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [3:0] pat4 [5] = '{4'h3, 4'hC, 4'h0, 4'hF, 4'h9};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         reset = 1'b0;
         d1    = pat[i];
         d4    = pat4[i];
         @(posedge clk);
         #1;
         vectors++;
         if (q1 !== pat[i]) begin
            miscompares++;
            $display("FAIL data_follow[%0d]: got %b want %b", i, q1, pat[i]);
         end
         vectors++;
         if (q4 !== pat4[i]) begin
            miscompares++;
            $display("FAIL data_follow4[%0d]: got %b want %b", i, q4, pat4[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      d1 = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_pre: got %b want 1", q1);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_clear: got %b want 0", q1);
      end
      @(negedge clk);
      reset = 1'b0;
      d1    = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_recover: got %b want 1", q1);
      end
   endtask

   task automatic test_reset_between_edges();
      // q is 1 here; a reset pulse confined to the low phase must be ignored
      @(negedge clk);
      d1 = 1'b1;
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (q1 !== 1'b1) begin
         miscompares++;
         $display("FAIL between_edges_pre: got %b want 1", q1);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (q1 !== 1'b1) begin
         miscompares++;
         $display("FAIL between_edges_post: got %b want 1", q1);
      end
   endtask

   task automatic test_random_soak();
      logic       exp1;
      logic [3:0] exp4;
      // reset toggles 3 ns after a rising edge and spans exactly the following edge
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         d1 = 1'($urandom_range(0, 1));
         d4 = 4'($urandom_range(0, 15));
         @(posedge clk);
         exp1 = reset ? 1'b0 : d1;
         exp4 = reset ? 4'b0000 : d4;
         #1;
         vectors++;
         if (q1 !== exp1) begin
            miscompares++;
            $display("FAIL soak[%0d]: got %b want %b", k, q1, exp1);
         end
         vectors++;
         if (q4 !== exp4) begin
            miscompares++;
            $display("FAIL soak4[%0d]: got %b want %b", k, q4, exp4);
         end
         #2;
         reset = (k == 1) || (k == 3);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_width4();
      logic [3:0] pats [2] = '{4'b1010, 4'b0101};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         reset = 1'b0;
         d4    = pats[i];
         @(posedge clk);
         #1;
         vectors++;
         if (q4 !== pats[i]) begin
            miscompares++;
            $display("FAIL width4[%0d]: got %b want %b", i, q4, pats[i]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (q4 !== 4'b0000) begin
         miscompares++;
         $display("FAIL width4_reset: got %b want 0000", q4);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      d1          = 1'b0;
      d4          = 4'b0000;
      test_reset();
      test_data_follow();
      test_mid_reset();
      test_reset_between_edges();
      test_random_soak();
      test_width4();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_dff_using_srff
